// File: rtl/serial_alu_pkg.sv
// serial_alu_pkg
//   Shared types and constants for the bit-serial add/sub sequencer.
//   - state_e : sequencer states IDLE / RUN / DONE
//   - OP_ADD / OP_SUB : encoding of the op input
package serial_alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/full_adder_1b.sv
// full_adder_1b
//   Single-bit full-adder cell; the only arithmetic resource of the serial adder.
//   Ports:
//     a, b, cin  in   operand bits and carry-in
//     sum        out  a ^ b ^ cin
//     cout       out  majority(a, b, cin)
module full_adder_1b (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_shift_reg.sv
// serial_shift_reg
//   WIDTH-bit register with parallel load and right shift; serial data enters at the MSB.
//   Load takes priority over shift.
//   Ports:
//     clock, reset  in   rising-edge clock, asynchronous active-high clear
//     load          in   capture load_data
//     shift         in   q <= {serial_in, q[WIDTH-1:1]}
//     load_data     in   WIDTH-bit parallel value
//     serial_in     in   bit shifted into the MSB
//     q             out  register contents
//     serial_out    out  current LSB
module serial_shift_reg #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] load_data,
    input  logic             serial_in,
    output logic [WIDTH-1:0] q,
    output logic             serial_out
);

    logic [WIDTH-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = load_data;
        end else if (shift) begin
            q_d = {serial_in, q_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q          = q_q;
    assign serial_out = q_q[0];

endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl
//   Bit-serial add/sub sequencer. One full-adder cell is time-shared over WIDTH cycles,
//   LSB first, to form a WIDTH-bit sum. Operands arrive on a valid/ready handshake and the
//   result leaves on a valid/ready handshake with carry and signed-overflow flags.
//   Optional feature macro: SERIAL_SUB_EN -- when defined, op=1 computes A-B as A + ~B + 1;
//   when undefined, op is ignored and every operation is an ADD.
//   Ports:
//     clock, reset          rising-edge clock, asynchronous active-high reset
//     in_valid / in_ready   operand handshake (in_ready high only in IDLE)
//     op                    0 = ADD, 1 = SUB
//     data_a, data_b        operands, sampled only on the accept edge
//     out_valid / out_ready result handshake (out_valid high only in DONE)
//     result                A+B or A-B, modulo 2^WIDTH
//     carry_out             carry out of the MSB (SUB: 1 = no borrow)
//     overflow              carry into MSB ^ carry out of MSB
module serial_adder_ctrl
    import serial_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);

    localparam int unsigned      CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             carry_q, carry_d;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             accept;
    logic             shift_en;
    logic             sub_sel;
    logic [WIDTH-1:0] b_load;
    logic             sa_bit, sb_bit;
    logic             fa_sum, fa_cout;
    logic [WIDTH-1:0] unused_sa_q, unused_sb_q;
    logic             unused_res_bit;

    assign accept   = (state_q == IDLE) && in_valid;
    assign shift_en = (state_q == RUN);

`ifdef SERIAL_SUB_EN
    assign sub_sel = (op == OP_SUB);
    assign b_load  = sub_sel ? ~data_b : data_b;
`else
    logic unused_op;
    assign unused_op = op;
    assign sub_sel   = OP_ADD;
    assign b_load    = data_b;
`endif

    serial_shift_reg #(.WIDTH(WIDTH)) u_sa (
        .clock      (clock),
        .reset      (reset),
        .load       (accept),
        .shift      (shift_en),
        .load_data  (data_a),
        .serial_in  (1'b0),
        .q          (unused_sa_q),
        .serial_out (sa_bit)
    );

    serial_shift_reg #(.WIDTH(WIDTH)) u_sb (
        .clock      (clock),
        .reset      (reset),
        .load       (accept),
        .shift      (shift_en),
        .load_data  (b_load),
        .serial_in  (1'b0),
        .q          (unused_sb_q),
        .serial_out (sb_bit)
    );

    // Result is cleared on accept so an aborted or previous operation leaves no residue;
    // after WIDTH shifts every bit has been replaced by a sum bit.
    serial_shift_reg #(.WIDTH(WIDTH)) u_res (
        .clock      (clock),
        .reset      (reset),
        .load       (accept),
        .shift      (shift_en),
        .load_data  ('0),
        .serial_in  (fa_sum),
        .q          (result),
        .serial_out (unused_res_bit)
    );

    full_adder_1b u_fa (
        .a    (sa_bit),
        .b    (sb_bit),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        carry_d     = carry_q;
        overflow_d  = overflow_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d    = RUN;
                    in_ready_d = 1'b0;
                    carry_d    = sub_sel;
                    cnt_d      = '0;
                end
            end
            RUN: begin
                carry_d = fa_cout;
                if (cnt_q == CNT_LAST) begin
                    // carry_q is the carry into the MSB on this last bit
                    overflow_d  = carry_q ^ fa_cout;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            carry_q     <= 1'b0;
            overflow_q  <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            carry_q     <= carry_d;
            overflow_q  <= overflow_d;
            cnt_q       <= cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign carry_out = carry_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl
//   Self-checking bench for serial_adder_ctrl at WIDTH=8, with a signed/unsigned
//   arithmetic reference model. Honours SERIAL_SUB_EN the same way as the design.
module tb_serial_adder_ctrl;

    localparam int W = 8;
`ifdef SERIAL_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic         clock = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic         op;
    logic [W-1:0] data_a;
    logic [W-1:0] data_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;

    int total = 0;
    int bad   = 0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .data_a    (data_a),
        .data_b    (data_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    always #5 clock = ~clock;

    // Returns {overflow, carry_out, result} from plain integer arithmetic.
    function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b, input logic o);
        int         sa, sb, s;
        logic [7:0] r;
        logic       c, v;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (SUB_EN && o) begin
            s = sa - sb;
            r = a - b;
            c = (a >= b);
        end else begin
            s = sa + sb;
            r = a + b;
            c = (int'(a) + int'(b)) > 255;
        end
        v = (s > 127) || (s < -128);
        return {v, c, r};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Presents one operation and steps through its accept edge.
    task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic o);
        int n = 0;
        while (!in_ready && n < 40) begin
            step();
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL start_timeout: in_ready=%0b required=1", in_ready);
        end
        data_a   = a;
        data_b   = b;
        op       = o;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            step();
            lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b0; op = 1'b0; data_a = '0; data_b = '0; out_ready = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL rst_in_ready: got %b required 1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
        total++; if (result !== 8'h00)   begin bad++; $display("FAIL rst_result: got %h required 00", result); end
        total++; if (carry_out !== 1'b0) begin bad++; $display("FAIL rst_carry: got %b required 0", carry_out); end
        total++; if (overflow !== 1'b0)  begin bad++; $display("FAIL rst_overflow: got %b required 0", overflow); end
        step(); step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_fixed(input string name, input logic [7:0] a, input logic [7:0] b,
                              input logic o, input logic [7:0] er, input logic ec, input logic ev);
        int lat;
        start_op(a, b, o);
        wait_valid(lat);
        total++; if (lat != W)        begin bad++; $display("FAIL %s_latency: got %0d required %0d", name, lat, W); end
        total++; if (result !== er)   begin bad++; $display("FAIL %s_result: got %h required %h", name, result, er); end
        total++; if (carry_out !== ec) begin bad++; $display("FAIL %s_carry: got %b required %b", name, carry_out, ec); end
        total++; if (overflow !== ev) begin bad++; $display("FAIL %s_overflow: got %b required %b", name, overflow, ev); end
        consume();
    endtask

    task automatic test_sub();
        if (SUB_EN) test_fixed("sub", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
        else        test_fixed("sub", 8'h05, 8'h07, 1'b1, 8'h0C, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        int         lat;
        logic [9:0] exp1;
        exp1 = model(8'h3C, 8'h11, 1'b0);
        start_op(8'h3C, 8'h11, 1'b0);
        wait_valid(lat);
        data_a = 8'h20; data_b = 8'h05; op = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid: got %b required 1", out_valid); end
            total++; if (in_ready !== 1'b0)  begin bad++; $display("FAIL bp_in_ready: got %b required 0", in_ready); end
            total++; if ({overflow, carry_out, result} !== exp1)
                begin bad++; $display("FAIL bp_hold: got %h required %h", {overflow, carry_out, result}, exp1); end
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid: got %b required 0", out_valid); end
        total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL bp_release_ready: got %b required 1", in_ready); end
        step();
        in_valid = 1'b0;
        total++; if (in_ready !== 1'b0)  begin bad++; $display("FAIL bp_reaccept: got in_ready=%b required 0", in_ready); end
        wait_valid(lat);
        total++; if (lat != W)           begin bad++; $display("FAIL bp_latency: got %0d required %0d", lat, W); end
        total++; if (result !== 8'h25)   begin bad++; $display("FAIL bp_result: got %h required 25", result); end
        consume();
    endtask

    task automatic test_reset_mid_run();
        start_op(8'hAA, 8'h55, 1'b0);
        repeat (4) step();
        reset = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL abort_in_ready: got %b required 1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL abort_out_valid: got %b required 0", out_valid); end
        total++; if (result !== 8'h00)   begin bad++; $display("FAIL abort_result: got %h required 00", result); end
        #2;
        reset = 1'b0;
        step();
        test_fixed("post_abort", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        int         lat;
        int         tries;
        logic [7:0] a, b;
        logic       o, r;
        logic [9:0] exp1;
        for (int i = 0; i < 100; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            o = 1'($urandom_range(0, 1));
            exp1 = model(a, b, o);
            start_op(a, b, o);
            // post-accept inputs are noise that must be ignored
            in_valid = 1'($urandom);
            data_a   = 8'($urandom);
            data_b   = 8'($urandom);
            op       = 1'($urandom);
            wait_valid(lat);
            total++; if (lat != W) begin bad++; $display("FAIL b2b_latency[%0d]: got %0d required %0d", i, lat, W); end
            total++; if ({overflow, carry_out, result} !== exp1)
                begin bad++; $display("FAIL b2b_result[%0d]: got %h required %h", i, {overflow, carry_out, result}, exp1); end
            tries = 0;
            do begin
                r = (tries >= 6) ? 1'b1 : 1'($urandom);
                out_ready = r;
                step();
                tries++;
                if (!r) begin
                    total++; if (out_valid !== 1'b1 || {overflow, carry_out, result} !== exp1)
                        begin bad++; $display("FAIL b2b_hold[%0d]: got v=%b %h required v=1 %h", i, out_valid, {overflow, carry_out, result}, exp1); end
                end
            end while (!r);
            out_ready = 1'b0;
        end
        in_valid = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_fixed("add_ovf", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        test_fixed("add_carry", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        test_sub();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
